// File: rtl/systolic_feeder_pkg.sv
// systolic_pkg: shared operand type, feeder FSM states and stream length helpers
package systolic_pkg;
  localparam int OPERAND_W = 10;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} feeder_state_t;
  function automatic int feed_len(input int size);
    return 2 * size - 1;
  endfunction
  function automatic int drain_len(input int size);
    return size;
  endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: feeder bus (master drives start/A_mat/B_mat, slave drives a_out/b_out/feeding/busy/done)
interface systolic_feeder_if #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 10
);
  logic                         start;
  logic signed [DATA_WIDTH-1:0] A_mat [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] B_mat [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] a_out [SIZE];
  logic signed [DATA_WIDTH-1:0] b_out [SIZE];
  logic                         feeding;
  logic                         busy;
  logic                         done;
  modport master (output start, A_mat, B_mat, input a_out, b_out, feeding, busy, done);
  modport slave  (input start, A_mat, B_mat, output a_out, b_out, feeding, busy, done);
endinterface

// File: rtl/systolic_feeder_skew_lane.sv
// skew_lane: drives vec[t-LANE] when en and 0 <= t-LANE < SIZE, else 0 (ports: en, t, vec in; out)
module skew_lane #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 10,
  parameter int LANE       = 0,
  parameter int CW         = 3
) (
  input  logic                         en,
  input  logic [CW-1:0]                t,
  input  logic signed [DATA_WIDTH-1:0] vec [SIZE],
  output logic signed [DATA_WIDTH-1:0] out
);
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  int d;
  logic [IW-1:0] idx;
  assign d   = int'(t) - LANE;
  assign idx = IW'(d);
  assign out = (en && d >= 0 && d < SIZE) ? vec[idx] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: captures A/B on start and streams them diagonally skewed into the array edges (clk, rst async active-low, bus slave)
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 10
) (
  input logic            clk,
  input logic            rst,
  systolic_feeder_if.slave bus
);
  localparam int CW = $clog2(2 * SIZE);
  localparam logic [CW-1:0] FEED_LAST  = CW'(feed_len(SIZE) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(SIZE) - 1);
  feeder_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic done_q, done_nx, accept, feeding;
  logic signed [DATA_WIDTH-1:0] a_q   [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] b_q   [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] b_col [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] a_o   [SIZE];
  logic signed [DATA_WIDTH-1:0] b_o   [SIZE];
  assign accept  = state == IDLE && bus.start;
  assign feeding = state == FEED;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        state_nx = bus.start ? FEED : IDLE;
        cnt_nx   = '0;
      end
      FEED: begin
        state_nx = cnt == FEED_LAST ? DRAIN : FEED;
        cnt_nx   = cnt == FEED_LAST ? '0 : cnt + CW'(1);
      end
      DRAIN: begin
        state_nx = cnt == DRAIN_LAST ? IDLE : DRAIN;
        cnt_nx   = cnt == DRAIN_LAST ? '0 : cnt + CW'(1);
        done_nx  = cnt == DRAIN_LAST;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else if (accept) begin
      a_q <= bus.A_mat;
      b_q <= bus.B_mat;
    end
  end
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    for (genvar k = 0; k < SIZE; k++) begin : g_col
      assign b_col[i][k] = b_q[k][i];
    end
    skew_lane #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .LANE(i), .CW(CW)) u_a (
      .en(feeding), .t(cnt), .vec(a_q[i]), .out(a_o[i])
    );
    skew_lane #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .LANE(i), .CW(CW)) u_b (
      .en(feeding), .t(cnt), .vec(b_col[i]), .out(b_o[i])
    );
  end
  assign bus.a_out   = a_o;
  assign bus.b_out   = b_o;
  assign bus.feeding = feeding;
  assign bus.busy    = state != IDLE;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random and directed stimulus checked every cycle against a cycle-count model of the feeder
module tb_systolic_feeder;
  import systolic_pkg::*;
  localparam int S  = 4;
  localparam int DW = 10;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  systolic_feeder_if #(.SIZE(S), .DATA_WIDTH(DW)) bus ();
  systolic_feeder #(.SIZE(S), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int k = -1;
  int cyc = 0;
  bit run = 0;
  operand_t ma [S][S];
  operand_t mb [S][S];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // k = cycles since the accepting edge; -1 when idle with nothing pending
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = -1;
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          ma[i][j] = '0;
          mb[i][j] = '0;
        end
    end else if (k < 0 || k == 3 * S - 1) begin
      if (bus.start) begin
        ma = bus.A_mat;
        mb = bus.B_mat;
        k = 0;
      end else k = -1;
    end else k++;
  end
  task automatic compare_all();
    logic [63:0] ea, eb, ga, gb;
    bit fe;
    int d;
    ea = '0; eb = '0; ga = '0; gb = '0;
    fe = k >= 0 && k <= 2 * S - 2;
    for (int i = 0; i < S; i++) begin
      d = k - i;
      ea[i*DW +: DW] = (fe && d >= 0 && d < S) ? ma[i][d] : '0;
      eb[i*DW +: DW] = (fe && d >= 0 && d < S) ? mb[d][i] : '0;
      ga[i*DW +: DW] = bus.a_out[i];
      gb[i*DW +: DW] = bus.b_out[i];
    end
    chk("a_out", ga, ea);
    chk("b_out", gb, eb);
    chk("feeding", 64'(bus.feeding), 64'(fe));
    chk("busy", 64'(bus.busy), 64'(k >= 0 && k <= 3 * S - 2));
    chk("done", 64'(bus.done), 64'(k == 3 * S - 1));
  endtask
  always @(negedge clk) begin
    cyc++;
    if (run) compare_all();
  end
  function automatic operand_t rnd();
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? operand_t'(-512) : r == 1 ? operand_t'(511) : operand_t'($urandom);
  endfunction
  task automatic set_rand();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        bus.A_mat[i][j] = rnd();
        bus.B_mat[i][j] = rnd();
      end
  endtask
  task automatic pulse_start();
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    set_rand();
  endtask
  task automatic measure(input string tag);
    int n, nb, nf;
    n = 0; nb = 0; nf = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
      nb += int'(bus.busy);
      nf += int'(bus.feeding);
    end
    chk({tag, "_done_lat"}, 64'(n), 64'(3 * S));
    chk({tag, "_busy_len"}, 64'(nb), 64'(3 * S - 1));
    chk({tag, "_feed_len"}, 64'(nf), 64'(2 * S - 1));
  endtask
  initial begin
    int n;
    int q[$];
    bus.start = 0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        bus.A_mat[i][j] = '0;
        bus.B_mat[i][j] = '0;
      end
    #2 rst = 0;
    run = 1;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_a0", 64'(bus.a_out[0]), 0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        bus.A_mat[i][j] = operand_t'(4 * i + j + 1);
        bus.B_mat[i][j] = operand_t'(-(4 * i + j + 1));
      end
    pulse_start();
    @(negedge clk);
    chk("pin_t0_a0", 64'(bus.a_out[0]), 64'(1));
    chk("pin_t0_b0", 64'(bus.b_out[0]), 64'(-1));
    chk("pin_t0_a1", 64'(bus.a_out[1]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pin_t3_a0", 64'(bus.a_out[0]), 64'(4));
    chk("pin_t3_a1", 64'(bus.a_out[1]), 64'(7));
    chk("pin_t3_a2", 64'(bus.a_out[2]), 64'(10));
    chk("pin_t3_a3", 64'(bus.a_out[3]), 64'(13));
    chk("pin_t3_b0", 64'(bus.b_out[0]), 64'(-13));
    chk("pin_t3_b3", 64'(bus.b_out[3]), 64'(-4));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pin_t6_a3", 64'(bus.a_out[3]), 64'(16));
    chk("pin_t6_b3", 64'(bus.b_out[3]), 64'(-16));
    chk("pin_t6_a0", 64'(bus.a_out[0]), 0);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        bus.A_mat[i][j] = operand_t'(i == j ? 1 : 0);
        bus.B_mat[i][j] = (i + j) % 2 == 0 ? operand_t'(-512) : operand_t'(511);
      end
    pulse_start();
    measure("ident");
    @(posedge clk);
    #1 pulse_start();
    @(posedge clk);
    #1 bus.start = 1;
    set_rand();
    @(posedge clk);
    #1 bus.start = 0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += int'(bus.done);
    end
    chk("ignored_start_dones", 64'(n), 64'(1));
    @(posedge clk);
    #1 bus.start = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) q.push_back(cyc);
      #2 set_rand();
    end
    @(posedge clk);
    #1 bus.start = 0;
    chk("b2b_count", 64'(q.size()), 64'(3));
    if (q.size() >= 3) begin
      chk("b2b_gap1", 64'(q[1] - q[0]), 64'(3 * S));
      chk("b2b_gap2", 64'(q[2] - q[1]), 64'(3 * S));
    end
    repeat (40) @(posedge clk);
    #1 pulse_start();
    repeat (2 * S - 1) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("arst_busy", 64'(bus.busy), 0);
    chk("arst_feeding", 64'(bus.feeding), 0);
    chk("arst_done", 64'(bus.done), 0);
    chk("arst_a", {bus.a_out[0], bus.a_out[1], bus.a_out[2], bus.a_out[3]}, 0);
    chk("arst_b", {bus.b_out[0], bus.b_out[1], bus.b_out[2], bus.b_out[3]}, 0);
    @(posedge clk);
    #1 rst = 1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(bus.done);
    end
    chk("arst_no_done", 64'(n), 0);
    @(posedge clk);
    #1 pulse_start();
    measure("post_rst");
    for (int it = 0; it < 25; it++) begin
      set_rand();
      for (int c = 0; c < 16; c++) begin
        bus.start = $urandom_range(0, 4) == 0;
        if ($urandom_range(0, 2) == 0) set_rand();
        @(posedge clk);
        #1;
      end
    end
    bus.start = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
